// File: rtl/control_pkg.sv
// Shared VeriRISC definitions: opcode encodings and phase width, used by the
// controller, instruction register and ALU.
package control_pkg;

  localparam int OP_W    = 3;
  localparam int PHASE_W = 3;

  localparam logic [OP_W-1:0] HLT = 3'd0;
  localparam logic [OP_W-1:0] SKZ = 3'd1;
  localparam logic [OP_W-1:0] ADD = 3'd2;
  localparam logic [OP_W-1:0] AND = 3'd3;
  localparam logic [OP_W-1:0] XOR = 3'd4;
  localparam logic [OP_W-1:0] LDA = 3'd5;
  localparam logic [OP_W-1:0] STO = 3'd6;
  localparam logic [OP_W-1:0] JMP = 3'd7;

  // Instructions that read an operand from memory into the accumulator path.
  function automatic logic is_aluop(input logic [OP_W-1:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/control.sv
// VeriRISC instruction-cycle controller: decodes opcode, phase and the
// accumulator zero flag into the nine datapath strobes. Purely combinational.
module control
  import control_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [OP_W-1:0]    opcode,
  input  logic [PHASE_W-1:0] phase,
  input  logic               zero,
  output logic               sel,
  output logic               rd,
  output logic               ld_ir,
  output logic               inc_pc,
  output logic               halt,
  output logic               ld_pc,
  output logic               data_e,
  output logic               ld_ac,
  output logic               wr
);

  // clk and rst exist only for port uniformity with the rest of the CPU.
  logic unused_ok;
  assign unused_ok = &{1'b0, clk, rst};

  logic alu;
  assign alu = is_aluop(opcode);

  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    case (phase)
      3'd0: sel = 1'b1;
      3'd1: begin
        sel = 1'b1;
        rd  = 1'b1;
      end
      3'd2, 3'd3: begin
        sel   = 1'b1;
        rd    = 1'b1;
        ld_ir = 1'b1;
      end
      3'd4: begin
        inc_pc = 1'b1;
        halt   = (opcode == HLT);
      end
      3'd5: rd = alu;
      3'd6: begin
        rd     = alu;
        inc_pc = (opcode == SKZ) && zero;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
      end
      3'd7: begin
        rd     = alu;
        ld_ac  = alu;
        ld_pc  = (opcode == JMP);
        data_e = (opcode == STO);
        wr     = (opcode == STO);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control.sv
// Scoreboard bench for the VeriRISC controller: directed vectors followed by
// an exhaustive sweep against an independent boolean model.
module tb_control;
  import control_pkg::*;

  logic clk = 1'b0;
  logic dut_clk;
  logic rst;
  logic [2:0] opcode;
  logic [2:0] phase;
  logic zero;
  logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

  logic vld = 1'b0;
  int   total = 0;
  int   bad   = 0;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } item_t;
  item_t sb[$];

  always #5 clk = ~clk;

  control dut (
    .clk    (dut_clk),
    .rst    (rst),
    .opcode (opcode),
    .phase  (phase),
    .zero   (zero),
    .sel    (sel),
    .rd     (rd),
    .ld_ir  (ld_ir),
    .inc_pc (inc_pc),
    .halt   (halt),
    .ld_pc  (ld_pc),
    .data_e (data_e),
    .ld_ac  (ld_ac),
    .wr     (wr)
  );

  wire [8:0] got = {sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr};

  function automatic logic [8:0] model(input logic [2:0] op, input logic [2:0] ph,
                                       input logic z);
    logic a;
    logic [8:0] v;
    a = (op >= 3'd2) && (op <= 3'd5);
    v[8] = (ph <= 3'd3);
    v[7] = ((ph >= 3'd1) && (ph <= 3'd3)) || (a && (ph >= 3'd5));
    v[6] = (ph == 3'd2) || (ph == 3'd3);
    v[5] = (ph == 3'd4) || ((ph == 3'd6) && (op == 3'd1) && z);
    v[4] = (ph == 3'd4) && (op == 3'd0);
    v[3] = (op == 3'd7) && (ph >= 3'd6);
    v[2] = (op == 3'd6) && (ph >= 3'd6);
    v[1] = a && (ph == 3'd7);
    v[0] = (op == 3'd6) && (ph == 3'd7);
    return v;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [2:0] ph, input logic z,
                       input logic [8:0] exp, input string name);
    item_t it;
    @(posedge clk);
    opcode = op;
    phase  = ph;
    zero   = z;
    it.exp  = exp;
    it.name = name;
    sb.push_back(it);
    vld = 1'b1;
  endtask

  // Monitor: the strobes are valid whenever the stimulus marks a vector live.
  initial begin
    item_t it;
    forever begin
      @(negedge clk);
      if (vld) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_underflow: got=%b required=pending entry", got);
        end else begin
          it = sb.pop_front();
          if ($isunknown(got) || got !== it.exp) begin
            bad++;
            $display("FAIL %s: op=%0d ph=%0d z=%b got=%b required=%b",
                     it.name, opcode, phase, zero, got, it.exp);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    dut_clk = 1'b0;
    opcode = '0; phase = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    rst = 1'b1;

    for (int o = 0; o < 8; o++) begin
      issue(3'(o), 3'd0, 1'b0, 9'b100000000, "fetch_p0");
      issue(3'(o), 3'd1, 1'b1, 9'b110000000, "fetch_p1");
      issue(3'(o), 3'd2, 1'b0, 9'b111000000, "fetch_p2");
      issue(3'(o), 3'd3, 1'b1, 9'b111000000, "fetch_p3");
    end

    issue(HLT, 3'd4, 1'b0, 9'b000110000, "hlt_p4");
    issue(HLT, 3'd5, 1'b1, 9'b000000000, "hlt_p5");
    issue(HLT, 3'd6, 1'b1, 9'b000000000, "hlt_p6");
    issue(HLT, 3'd7, 1'b0, 9'b000000000, "hlt_p7");

    issue(SKZ, 3'd4, 1'b1, 9'b000100000, "skz_p4");
    issue(SKZ, 3'd6, 1'b0, 9'b000000000, "skz_p6_z0");
    issue(SKZ, 3'd6, 1'b1, 9'b000100000, "skz_p6_z1");
    issue(SKZ, 3'd7, 1'b1, 9'b000000000, "skz_p7_z1");

    for (int o = 2; o <= 5; o++) begin
      issue(3'(o), 3'd4, 1'b0, 9'b000100000, "alu_p4");
      issue(3'(o), 3'd5, 1'b1, 9'b010000000, "alu_p5");
      issue(3'(o), 3'd6, 1'b1, 9'b010000000, "alu_p6");
      issue(3'(o), 3'd7, 1'b0, 9'b010000010, "alu_p7");
    end

    issue(STO, 3'd5, 1'b0, 9'b000000000, "sto_p5");
    issue(STO, 3'd6, 1'b1, 9'b000000100, "sto_p6");
    issue(STO, 3'd7, 1'b0, 9'b000000101, "sto_p7");
    issue(JMP, 3'd5, 1'b1, 9'b000000000, "jmp_p5");
    issue(JMP, 3'd6, 1'b0, 9'b000001000, "jmp_p6");
    issue(JMP, 3'd7, 1'b1, 9'b000001000, "jmp_p7");

    // Sweep with reset/clock undriven, then unknown, then toggling.
    for (int pass = 0; pass < 3; pass++) begin
      for (int i = 0; i < 128; i++) begin
        logic [6:0] v;
        v = 7'(i);
        if (pass == 0) begin rst = 1'bz; dut_clk = 1'bz; end
        else if (pass == 1) begin rst = 1'bx; dut_clk = 1'bx; end
        else begin rst = v[0]; dut_clk = ~dut_clk; end
        issue(v[6:4], v[3:1], v[0], model(v[6:4], v[3:1], v[0]), "sweep");
      end
    end

    @(posedge clk);
    vld = 1'b0;
    repeat (2) @(posedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got=%0d leftover required=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=no finish required=finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/control.md
# control

Combinational instruction-cycle controller for the VeriRISC CPU. It decodes the 3-bit opcode, the 3-bit phase from the external phase counter, and the accumulator zero flag into nine active-high strobes. These strobes drive the address mux, memory, instruction register, program counter, accumulator and data-bus driver. It sits between the phase counter / instruction register and the datapath and holds no state.

## Interface
Parameters: none. Opcode encodings come from the shared package.

- clk  input  1  system clock; single clock domain; no internal logic uses it (reserved for interface uniformity)
- rst  input  1  asynchronous, active-low reset; no internal logic uses it; outputs never depend on it
- opcode  input  3  current instruction opcode from the IR
- phase  input  3  current cycle phase 0..7
- zero  input  1  accumulator equals zero
- sel  output  1  select PC as memory address
- rd  output  1  enable memory output onto data bus
- ld_ir  output  1  load instruction register
- inc_pc  output  1  increment program counter
- halt  output  1  halt machine
- ld_pc  output  1  load program counter
- data_e  output  1  enable accumulator output onto data bus
- ld_ac  output  1  load accumulator from data bus
- wr  output  1  write data bus to memory

## Operation
- Opcodes: HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- ALUOP = ADD, AND, XOR or LDA.
- Every output not listed for a given phase is 0.
- Phase 0: sel.
- Phase 1: sel, rd.
- Phases 2 and 3: sel, rd, ld_ir.
- Phase 4: inc_pc for all opcodes; halt additionally when opcode = HLT.
- Phase 5: rd when ALUOP; otherwise nothing.
- Phase 6: rd when ALUOP; inc_pc when opcode = SKZ and zero = 1; ld_pc when JMP; data_e when STO.
- Phase 7: rd and ld_ac when ALUOP; ld_pc when JMP; data_e and wr when STO.
- zero affects only SKZ in phase 6. It is ignored in all other phase/opcode combinations, including SKZ in phase 7.
- HLT produces nothing after phase 4.
- All outputs are known (no X) for every 3-bit combination of opcode and phase.

## Timing
- Purely combinational: outputs settle within one delta after any input change. There is zero cycle latency.
- No registers, so no reset values. Outputs follow the inputs regardless of the level of rst and of clk activity, including when rst or clk are undriven.
- The surrounding datapath samples the strobes on the clk edge that ends each phase. The phase counter advances one phase per clock.
- Simultaneous changes of opcode, phase and zero produce the decode for the new input values only. There is no glitch filtering.

## Structure
- Shared package holds the opcode localparams (HLT..JMP) and the phase width. The instruction register and ALU use the same package.
- Implement as a single always-comb case on phase with nested opcode checks. Default-assign all outputs to 0 first.
- No sub-module.

## Test plan
- Fetch phases: opcode=HLT, phase 0/1/2/3 -> {sel,rd,ld_ir,inc_pc,halt,ld_pc,data_e,ld_ac,wr} = 100000000 / 110000000 / 111000000 / 111000000. Repeat for all 8 opcodes with identical results.
- HLT: phase 4 -> 000110000; phases 5–7 -> 000000000.
- SKZ: zero=0, phase 6 -> 000000000; zero=1, phase 6 -> 000100000 (inc_pc); phase 7 with zero=1 -> 000000000.
- ADD/AND/XOR/LDA: phase 4 -> 000100000; phases 5 and 6 -> 010000000; phase 7 -> 010000010.
- STO: phase 5 -> 000000000; phase 6 -> 000000100; phase 7 -> 000000101. JMP: phase 5 -> 000000000; phases 6 and 7 -> 000001000.
- Exhaustive sweep: all 128 {opcode,phase,zero} combinations with rst and clk undriven or toggling -> outputs match the decode rules, no X.
